// File: rtl/spi_flash_rd_ctrl.sv
// Read-only SPI flash controller: issues READ (CMD + 24-bit address) in SPI mode 0
// and returns 1-4 data bytes packed little-endian with a single-cycle response pulse.
module spi_flash_rd_ctrl #(
  parameter int         DIV = 2,
  parameter logic [7:0] CMD = 8'h03
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        req_cs,
  input  logic [1:0]  req_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk,
  output logic [1:0]  spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] rx_q, rx_d;
  logic [1:0]  len_q, len_d;
  logic        spi_clk_q, spi_clk_d;
  logic [1:0]  spi_cs_q, spi_cs_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic       div_done;
  logic [5:0] last_bit;
  logic [4:0] rx_idx;

  assign div_done = (div_cnt_q == DIV_LAST);
  // Index of the final bit: 32 header bits plus 8 per requested byte.
  assign last_bit = 6'd39 + {1'b0, len_q, 3'b000};
  // Data bit d lands in byte d/8 at position 7 - d%8 (MSB first on the wire).
  assign rx_idx   = {bit_cnt_q[4:3], ~bit_cnt_q[2:0]};

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    len_d       = len_q;
    spi_clk_d   = spi_clk_q;
    spi_cs_d    = spi_cs_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        spi_clk_d = 1'b0;
        spi_cs_d  = 2'b11;
        div_cnt_d = 8'd0;
        if (req_valid) begin
          state_d  = SETUP;
          shift_d  = {CMD, req_addr};
          len_d    = req_len;
          rx_d     = 32'd0;
          spi_cs_d = req_cs ? 2'b01 : 2'b10;
        end
      end
      SETUP: begin
        if (div_done) begin
          state_d   = SHIFT;
          div_cnt_d = 8'd0;
          bit_cnt_d = 6'd0;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (!div_done) begin
          div_cnt_d = div_cnt_q + 8'd1;
        end else begin
          div_cnt_d = 8'd0;
          if (!spi_clk_q) begin
            spi_clk_d = 1'b1;
          end else begin
            // End of high phase: sample MISO and advance MOSI on the falling edge.
            spi_clk_d = 1'b0;
            if (bit_cnt_q[5]) begin
              rx_d[rx_idx] = spi_miso;
            end
            shift_d = {shift_q[30:0], 1'b0};
            if (bit_cnt_q == last_bit) begin
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
      end
      HOLD: begin
        if (div_done) begin
          state_d     = IDLE;
          div_cnt_d   = 8'd0;
          spi_cs_d    = 2'b11;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= 8'd0;
      bit_cnt_q   <= 6'd0;
      shift_q     <= 32'd0;
      rx_q        <= 32'd0;
      len_q       <= 2'd0;
      spi_clk_q   <= 1'b0;
      spi_cs_q    <= 2'b11;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      len_q       <= len_d;
      spi_clk_q   <= spi_clk_d;
      spi_cs_q    <= spi_cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // The shift word's MSB is MOSI; it drains to zero before the data phase.
  assign spi_mosi  = shift_q[31];
  assign spi_clk   = spi_clk_q;
  assign spi_cs    = spi_cs_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE) && !sys_rst;

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: a DIV=2 and a DIV=1 instance share stimulus; a per-cycle
// timeline model derived from the transaction timing rules checks every output.
module tb_spi_flash_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = 24'd0;
  logic        req_cs = 1'b0;
  logic [1:0]  req_len = 2'd0;

  logic        req_ready_w[2];
  logic        rsp_valid_w[2];
  logic [31:0] rsp_data_w[2];
  logic        busy_w[2];
  logic        spi_clk_w[2];
  logic [1:0]  spi_cs_w[2];
  logic        spi_mosi_w[2];
  logic        spi_miso_r[2] = '{1'b0, 1'b0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      spi_flash_rd_ctrl #(.DIV(gi == 0 ? 2 : 1), .CMD(8'h03)) u_dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .req_valid(req_valid),
        .req_ready(req_ready_w[gi]),
        .req_addr (req_addr),
        .req_cs   (req_cs),
        .req_len  (req_len),
        .rsp_valid(rsp_valid_w[gi]),
        .rsp_data (rsp_data_w[gi]),
        .busy     (busy_w[gi]),
        .spi_clk  (spi_clk_w[gi]),
        .spi_cs   (spi_cs_w[gi]),
        .spi_mosi (spi_mosi_w[gi]),
        .spi_miso (spi_miso_r[gi])
      );
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'hFFFFFF: return 8'hA5;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A ^ {a[2:0], 5'b0};
    endcase
  endfunction

  // Transaction timeline model (per instance)
  bit          act[2]      = '{0, 0};
  int          c0[2]       = '{0, 0};
  logic [23:0] m_addr[2];
  logic        m_cs[2];
  logic [1:0]  m_len[2];
  logic [31:0] exp_data[2] = '{32'd0, 32'd0};
  int          acc_cnt[2]  = '{0, 0};
  // Observations of the DUT pins
  int          rsp_cnt[2]  = '{0, 0};
  int          dut_acc[2]  = '{0, 0};
  int          lat[2]      = '{0, 0};
  int          rises[2]    = '{0, 0};
  logic [31:0] got_data[2];
  // Flash device model
  int          fcnt[2]     = '{0, 0};
  logic [31:0] fsh[2]      = '{32'd0, 32'd0};
  logic        fprev[2]    = '{1'b0, 1'b0};
  bit          rst_prev    = 1'b1;

  always @(negedge clk) begin : p_model
    int d, t, bits, n, u, b, nb;
    logic [31:0] word;
    logic [7:0]  fb;
    logic [1:0]  e_cs;
    logic        e_clk, e_mosi, e_busy, e_rv, e_ready;
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        d = (i == 0) ? 2 : 1;
        if (rst_prev) begin
          act[i]      = 1'b0;
          exp_data[i] = 32'd0;
        end
        e_cs = 2'b11; e_clk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_rv = 1'b0;
        e_ready = !rst;
        if (act[i]) begin
          t    = cyc - c0[i];
          bits = 32 + 8 * (int'(m_len[i]) + 1);
          n    = d * (2 * bits + 2);
          word = {8'h03, m_addr[i]};
          if (t <= n) begin
            e_busy = 1'b1; e_ready = 1'b0;
            e_cs   = m_cs[i] ? 2'b01 : 2'b10;
            if (t <= d) begin
              e_mosi = word[31];
            end else if (t <= d + 2 * d * bits) begin
              u      = t - d - 1;
              b      = u / (2 * d);
              e_clk  = (u % (2 * d)) >= d;
              e_mosi = (b < 32) ? word[31 - b] : 1'b0;
            end
          end else begin
            e_rv = 1'b1;
            exp_data[i] = 32'd0;
            for (int k = 0; k <= int'(m_len[i]); k++)
              exp_data[i][8*k +: 8] = flash_byte(m_addr[i] + 24'(k));
            check($sformatf("rises[%0d]@%0d", i, cyc), 64'(rises[i]), 64'(bits));
            act[i] = 1'b0;
          end
        end
        check($sformatf("pins[%0d]@%0d {rdy,busy,rv,clk,cs,mosi}", i, cyc),
              {57'd0, req_ready_w[i], busy_w[i], rsp_valid_w[i], spi_clk_w[i], spi_cs_w[i], spi_mosi_w[i]},
              {57'd0, e_ready, e_busy, e_rv, e_clk, e_cs, e_mosi});
        check($sformatf("rsp_data[%0d]@%0d", i, cyc), {32'd0, rsp_data_w[i]}, {32'd0, exp_data[i]});

        if (rsp_valid_w[i] === 1'b1) begin
          rsp_cnt[i]++;
          lat[i]      = cyc - dut_acc[i];
          got_data[i] = rsp_data_w[i];
        end
        if (req_ready_w[i] === 1'b1 && req_valid) begin
          dut_acc[i] = cyc;
          rises[i]   = 0;
        end
        if (spi_clk_w[i] && !fprev[i]) rises[i]++;

        if (!act[i] && !rst && req_valid) begin
          act[i]    = 1'b1;
          c0[i]     = cyc;
          m_addr[i] = req_addr;
          m_cs[i]   = req_cs;
          m_len[i]  = req_len;
          acc_cnt[i]++;
        end

        // Flash: shift in command/address on rises, drive data after each fall.
        if (spi_cs_w[i] === 2'b11) begin
          fcnt[i]       = 0;
          spi_miso_r[i] = 1'b0;
        end else begin
          if (spi_clk_w[i] && !fprev[i]) begin
            if (fcnt[i] < 32) fsh[i] = {fsh[i][30:0], spi_mosi_w[i]};
            fcnt[i]++;
          end
          if (!spi_clk_w[i] && fprev[i] && fcnt[i] >= 32) begin
            nb = fcnt[i] - 32;
            fb = flash_byte(fsh[i][23:0] + 24'(nb / 8));
            spi_miso_r[i] = fb[7 - (nb % 8)];
          end
        end
        fprev[i] = spi_clk_w[i];
      end
    end
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc0();
    int s, k;
    s = acc_cnt[0];
    k = 0;
    while (acc_cnt[0] == s && k < 2000) begin tick(); k++; end
    check("accept0 within bound", 64'(acc_cnt[0] != s), 64'd1);
  endtask

  task automatic wait_rsp0();
    int s, k;
    s = rsp_cnt[0];
    k = 0;
    while (rsp_cnt[0] == s && k < 2000) begin tick(); k++; end
    check("response0 within bound", 64'(rsp_cnt[0] != s), 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < 3000) begin tick(); k++; end
    check("idle within bound", 64'(act[0] || act[1]), 64'd0);
  endtask

  initial begin
    int a1, r0, r1, lim;

    // Reset with random inputs
    repeat (3) begin
      req_valid = 1'($urandom); req_addr = 24'($urandom);
      req_cs = 1'($urandom); req_len = 2'($urandom);
      tick();
    end
    check("ready during reset", {63'd0, req_ready_w[0]}, 64'd0);
    check("cs during reset", {62'd0, spi_cs_w[0]}, 64'd3);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("ready after reset", {62'd0, req_ready_w[0], req_ready_w[1]}, 64'd3);

    // 4-byte read from 0x000100 on CS0
    tick();
    req_addr = 24'h000100; req_cs = 1'b0; req_len = 2'd3; req_valid = 1'b1;
    wait_acc0();
    req_valid = 1'b0;
    wait_rsp0();
    check("t2 latency", 64'(lat[0]), 64'd261);
    check("t2 data", {32'd0, got_data[0]}, 64'h44332211);
    check("t2 rises", 64'(rises[0]), 64'd64);

    // 1-byte read from 0xFFFFFF on CS1
    wait_idle();
    req_addr = 24'hFFFFFF; req_cs = 1'b1; req_len = 2'd0; req_valid = 1'b1;
    wait_acc0();
    req_valid = 1'b0;
    wait_rsp0();
    check("t3 latency", 64'(lat[0]), 64'd165);
    check("t3 data", {32'd0, got_data[0]}, 64'h000000A5);
    check("t3 rises", 64'(rises[0]), 64'd40);

    // Back-to-back with req_valid held high
    wait_idle();
    req_addr = 24'h000000; req_cs = 1'b0; req_len = 2'd3; req_valid = 1'b1;
    wait_acc0();
    a1 = dut_acc[0];
    req_addr = 24'h000004;
    wait_acc0();
    req_valid = 1'b0;
    check("t4 second accept offset", 64'(dut_acc[0] - a1), 64'd261);
    wait_rsp0();

    // Reset during the 10th data bit
    wait_idle();
    req_addr = 24'h000100; req_cs = 1'b0; req_len = 2'd3; req_valid = 1'b1;
    wait_acc0();
    req_valid = 1'b0;
    r0 = rsp_cnt[0];
    lim = 0;
    while (cyc < c0[0] + 168 && lim < 500) begin tick(); lim++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 cs after reset", {62'd0, spi_cs_w[0]}, 64'd3);
    check("t5 clk after reset", {63'd0, spi_clk_w[0]}, 64'd0);
    repeat (300) tick();
    check("t5 no response", 64'(rsp_cnt[0] - r0), 64'd0);
    req_addr = 24'h000100; req_len = 2'd3; req_valid = 1'b1;
    wait_acc0();
    req_valid = 1'b0;
    wait_rsp0();
    check("t5 data", {32'd0, got_data[0]}, 64'h44332211);

    // DIV=1 instance: extra pulse while busy is ignored
    wait_idle();
    r1 = rsp_cnt[1];
    req_addr = 24'h000200; req_cs = 1'b0; req_len = 2'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    req_addr = 24'h000300; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_idle();
    check("t6 response count", 64'(rsp_cnt[1] - r1), 64'd1);
    check("t6 latency", 64'(lat[1]), 64'd83);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      req_addr = 24'($urandom); req_cs = 1'($urandom); req_len = 2'($urandom);
      req_valid = 1'b1;
      wait_acc0();
      repeat ($urandom_range(0, 2)) tick();
      req_valid = 1'b0;
      req_addr = 24'($urandom);
      if ($urandom_range(0, 1) == 1) wait_rsp0();
    end

    wait_idle();
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
